// File: rtl/sisc_exec_ctrl.sv
// SISC multicycle execution core: control FSM, 32-bit ALU with result register,
// and write-back multiplexer. Register file, status register and fetch are external.
module sisc_exec_ctrl (
  input  logic        clk,
  input  logic        rst_f,
  input  logic [31:0] ir,
  input  logic [31:0] rsa,
  input  logic [31:0] rsb,
  input  logic [3:0]  stat,
  output logic [1:0]  alu_op,
  output logic [31:0] alu_result,
  output logic        rf_we,
  output logic        wb_sel,
  output logic [31:0] rf_write_data,
  output logic [3:0]  stat_in,
  output logic        stat_en,
  output logic        br_taken,
  output logic        halted
);

  typedef enum logic [2:0] {
    START0    = 3'd0,
    START1    = 3'd1,
    FETCH     = 3'd2,
    DECODE    = 3'd3,
    EXECUTE   = 3'd4,
    MEM       = 3'd5,
    WRITEBACK = 3'd6,
    HALT      = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_ALU  = 4'b0001,
    OP_ADDI = 4'b0010,
    OP_LI   = 4'b0011,
    OP_BR   = 4'b0100,
    OP_HALT = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    AOP_REG  = 2'b00,
    AOP_ADDI = 2'b01,
    AOP_PASS = 2'b10,
    AOP_IDLE = 2'b11
  } aop_t;

  state_t      state, state_next;
  logic [3:0]  opcode, mm, funct;
  logic [31:0] imm_z;
  logic        unused_fields;

  assign opcode        = ir[31:28];
  assign mm            = ir[27:24];
  assign funct         = ir[3:0];
  assign imm_z         = {16'h0000, ir[15:0]};
  assign unused_fields = ^ir[23:16];

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= START0;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_op     = AOP_IDLE;
    rf_we      = 1'b0;
    wb_sel     = 1'b0;
    stat_en    = 1'b0;
    br_taken   = 1'b0;
    halted     = 1'b0;
    case (state)
      START0:  state_next = START1;
      START1:  state_next = FETCH;
      FETCH:   state_next = DECODE;
      DECODE:  state_next = (opcode == OP_HALT) ? HALT : EXECUTE;
      EXECUTE: begin
        state_next = MEM;
        case (opcode)
          OP_ALU:  begin alu_op = AOP_REG;  stat_en = 1'b1; end
          OP_ADDI: begin alu_op = AOP_ADDI; stat_en = 1'b1; end
          OP_LI:   alu_op = AOP_PASS;
          OP_BR:   br_taken = (mm == 4'b0000) || ((stat & mm) != 4'b0000);
          default: ;
        endcase
      end
      MEM:       state_next = WRITEBACK;
      WRITEBACK: begin
        state_next = FETCH;
        if (opcode == OP_ALU || opcode == OP_ADDI || opcode == OP_LI) begin
          rf_we  = 1'b1;
          wb_sel = 1'b1;
        end
      end
      HALT: begin
        state_next = HALT;
        halted     = 1'b1;
      end
      default: state_next = START0;
    endcase
  end

  // ---------------- ALU ----------------
  logic [31:0] alu_y, add_b;
  logic [32:0] sum;
  logic        add_cin, arith, idle;

  // One shared adder serves ADD, SUB (rsa + ~rsb + 1) and ADDI.
  always_comb begin
    alu_y   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    arith   = 1'b0;
    idle    = 1'b0;
    case (alu_op)
      AOP_REG: begin
        case (funct)
          4'b0001: begin add_b = rsb; arith = 1'b1; end
          4'b0010: begin add_b = ~rsb; add_cin = 1'b1; arith = 1'b1; end
          4'b0011: alu_y = ~rsa;
          4'b0100: alu_y = rsa | rsb;
          4'b0101: alu_y = rsa & rsb;
          4'b0110: alu_y = rsa ^ rsb;
          4'b0111: alu_y = rsa << rsb[4:0];
          4'b1000: alu_y = rsa >> rsb[4:0];
          default: alu_y = '0;
        endcase
      end
      AOP_ADDI: begin add_b = imm_z; arith = 1'b1; end
      AOP_PASS: alu_y = imm_z;
      default:  idle = 1'b1;
    endcase
    sum = {1'b0, rsa} + {1'b0, add_b} + {32'h0, add_cin};
    if (arith) alu_y = sum[31:0];
  end

  logic flag_c, flag_v;
  assign flag_c  = arith & sum[32];
  assign flag_v  = arith & (rsa[31] == add_b[31]) & (sum[31] != rsa[31]);
  assign stat_in = idle ? 4'b0000 : {flag_c, flag_v, alu_y[31], (alu_y == 32'h0)};

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)                alu_result <= '0;
    else if (state == EXECUTE) alu_result <= alu_y;
  end

  assign rf_write_data = wb_sel ? alu_result : 32'h0;

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Scoreboard bench for sisc_exec_ctrl: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_sisc_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic [31:0] ir = '0, rsa = '0, rsb = '0;
  logic [3:0]  stat = '0;
  logic [1:0]  alu_op;
  logic [31:0] alu_result, rf_write_data;
  logic        rf_we, wb_sel, stat_en, br_taken, halted;
  logic [3:0]  stat_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [1:0]  aop;
    logic        we;
    logic        sen;
    logic        br;
    logic        hlt;
    logic [3:0]  st;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];

  sisc_exec_ctrl dut (
    .clk(clk), .rst_f(rst_f), .ir(ir), .rsa(rsa), .rsb(rsb), .stat(stat),
    .alu_op(alu_op), .alu_result(alu_result), .rf_we(rf_we), .wb_sel(wb_sel),
    .rf_write_data(rf_write_data), .stat_in(stat_in), .stat_en(stat_en),
    .br_taken(br_taken), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got no finish, required finish)");
    $fatal(1, "watchdog");
  end

  // Monitor: one expected record per clock cycle while the queue is non-empty.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (alu_op !== e.aop || rf_we !== e.we || wb_sel !== e.we || stat_en !== e.sen ||
          br_taken !== e.br || halted !== e.hlt || stat_in !== e.st || rf_write_data !== e.wd) begin
        errors++;
        $display("FAIL %s: got aop=%b we=%b wb=%b sen=%b br=%b h=%b st=%b wd=%h, required aop=%b we=%b wb=%b sen=%b br=%b h=%b st=%b wd=%h",
                 e.name, alu_op, rf_we, wb_sel, stat_en, br_taken, halted, stat_in, rf_write_data,
                 e.aop, e.we, e.we, e.sen, e.br, e.hlt, e.st, e.wd);
      end
    end
  end

  function automatic exp_t rec(string name, logic [1:0] aop, logic we, logic sen,
                               logic br, logic hlt, logic [3:0] st, logic [31:0] wd);
    exp_t e;
    e.name = name; e.aop = aop; e.we = we; e.sen = sen;
    e.br = br; e.hlt = hlt; e.st = st; e.wd = wd;
    return e;
  endfunction

  function automatic exp_t idle_rec(string name);
    return rec(name, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0);
  endfunction

  // Immediate check of the cleared output set (used while reset is asserted).
  task automatic check_cleared(input string name);
    checks++;
    if (alu_op !== 2'b11 || alu_result !== 32'h0 || rf_we !== 1'b0 || wb_sel !== 1'b0 ||
        stat_en !== 1'b0 || br_taken !== 1'b0 || halted !== 1'b0 || rf_write_data !== 32'h0 ||
        stat_in !== 4'b0000) begin
      errors++;
      $display("FAIL %s: got aop=%b res=%h we=%b wb=%b sen=%b br=%b h=%b wd=%h st=%b, required aop=11 res=0 all controls 0",
               name, alu_op, alu_result, rf_we, wb_sel, stat_en, br_taken, halted, rf_write_data, stat_in);
    end
  endtask

  // Called at FETCH+1; returns at next FETCH+1.
  task automatic issue(input string name, input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] s, input logic [1:0] aop,
                       input logic sen, input logic [3:0] st, input logic br,
                       input logic we, input logic [31:0] wd);
    ir = i; rsa = a; rsb = b; stat = s;
    q.push_back(idle_rec({name, "_fetch"}));
    q.push_back(idle_rec({name, "_decode"}));
    q.push_back(rec({name, "_exec"}, aop, 1'b0, sen, br, 1'b0, st, 32'h0));
    q.push_back(idle_rec({name, "_mem"}));
    q.push_back(rec({name, "_wb"}, 2'b11, we, 1'b0, 1'b0, 1'b0, 4'b0000, we ? wd : 32'h0));
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic release_reset(input string name);
    repeat (2) @(posedge clk);
    #1 rst_f = 1'b1;
    q.push_back(idle_rec({name, "_start0"}));
    q.push_back(idle_rec({name, "_start1"}));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_f = 1'b0;
    #1 check_cleared("reset_initial");
    release_reset("boot");

    //     name          ir            rsa           rsb           stat   aop    sen  st       br   we   wdata
    issue("add_ovf",  32'h1012_3001, 32'h7FFF_FFFF, 32'h0000_0001, 4'h0, 2'b00, 1'b1, 4'b0110, 1'b0, 1'b1, 32'h8000_0000);
    issue("sub_zero", 32'h1012_3002, 32'h0000_0005, 32'h0000_0005, 4'h0, 2'b00, 1'b1, 4'b1001, 1'b0, 1'b1, 32'h0000_0000);
    issue("li",       32'h3100_BEEF, 32'h1234_5678, 32'h0,         4'h0, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h0000_BEEF);
    issue("addi_c",   32'h2120_FFFF, 32'hFFFF_0001, 32'h0,         4'h0, 2'b01, 1'b1, 4'b1001, 1'b0, 1'b1, 32'h0000_0000);
    issue("and",      32'h1012_3005, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h0, 2'b00, 1'b1, 4'b0010, 1'b0, 1'b1, 32'hF000_F000);
    issue("xor",      32'h1012_3006, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h0, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b1, 32'h0FF0_0FF0);
    issue("shl",      32'h1012_3007, 32'h0000_0001, 32'h0000_0023, 4'h0, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b1, 32'h0000_0008);
    issue("shr",      32'h1012_3008, 32'h8000_0000, 32'h0000_001F, 4'h0, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b1, 32'h0000_0001);
    issue("not",      32'h1012_3003, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 1'b1, 4'b0010, 1'b0, 1'b1, 32'hFFFF_FFFF);
    issue("or_zero",  32'h1012_3004, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 1'b1, 4'b0001, 1'b0, 1'b1, 32'h0000_0000);
    issue("add_c",    32'h1012_3001, 32'hFFFF_FFFF, 32'h0000_0001, 4'h0, 2'b00, 1'b1, 4'b1001, 1'b0, 1'b1, 32'h0000_0000);
    issue("sub_neg",  32'h1012_3002, 32'h0000_0003, 32'h0000_0005, 4'h0, 2'b00, 1'b1, 4'b0010, 1'b0, 1'b1, 32'hFFFF_FFFE);
    issue("bad_fn",   32'h1012_3009, 32'h1234_5678, 32'h0000_0001, 4'h0, 2'b00, 1'b1, 4'b0001, 1'b0, 1'b1, 32'h0000_0000);
    issue("br_hit",   32'h4100_0000, 32'h0,         32'h0,         4'h1, 2'b11, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0);
    issue("br_miss",  32'h4400_0000, 32'h0,         32'h0,         4'h1, 2'b11, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0);
    issue("br_always",32'h4000_0000, 32'h0,         32'h0,         4'h0, 2'b11, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0);
    issue("br_c",     32'h4800_0000, 32'h0,         32'h0,         4'h8, 2'b11, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0);
    issue("nop",      32'h0000_0000, 32'h1,         32'h1,         4'hF, 2'b11, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0);
    issue("op5_nop",  32'h5012_3001, 32'h1,         32'h1,         4'h0, 2'b11, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0);
    issue("add_pre",  32'h1012_3001, 32'h0000_1000, 32'h0000_0234, 4'h0, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b1, 32'h0000_1234);

    // Abort an ADD in EXECUTE; alu_result still holds 0x1234 from add_pre.
    ir = 32'h1012_3001; rsa = 32'h0000_0011; rsb = 32'h0000_0022; stat = 4'h0;
    q.push_back(idle_rec("abort_fetch"));
    q.push_back(idle_rec("abort_decode"));
    q.push_back(rec("abort_exec", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_f = 1'b0;
    #1 check_cleared("reset_mid_exec");
    release_reset("after_abort");

    issue("li_post",  32'h3100_00A5, 32'h0,         32'h0,         4'h0, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h0000_00A5);

    // HALT: halted from the cycle after DECODE, no writes.
    ir = 32'hF000_0000;
    q.push_back(idle_rec("halt_fetch"));
    q.push_back(idle_rec("halt_decode"));
    for (int unsigned k = 0; k < 10; k++)
      q.push_back(rec("halt_hold", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0));
    repeat (12) @(posedge clk);
    #1;

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending records, required 0", q.size());
    end

    rst_f = 1'b0;
    #1 check_cleared("reset_from_halt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
